multicycle_control: RTL and testbench

Parametrised multicycle successor to the single-cycle main decoder. A Moore FSM sequences each instruction (rtype, lw, sw, beq, bne, addi, j, jalfor) through fetch, decode, execute, memory and writeback steps over a shared memory/ALU datapath. It waits on a memory ready handshake with a bounded timeout, and flags illegal opcodes. It sits between the instruction register and the multicycle datapath muxes and enables.

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
  parameter int OPCODE_W = 8
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_ne;
  logic [1:0]          pc_src;
  logic                ir_write;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic [1:0]          reg_dst;
  logic [1:0]          wb_sel;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                retire;
  logic                illegal;
  logic                fault;
  logic [3:0]          state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_src, ir_write, iord,
           mem_read, mem_write, reg_dst, wb_sel, reg_write, alu_src_a,
           alu_src_b, alu_op, retire, illegal, fault, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_src, ir_write, iord,
           mem_read, mem_write, reg_dst, wb_sel, reg_write, alu_src_a,
           alu_src_b, alu_op, retire, illegal, fault, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style multicycle main controller with memory-ready timeout and illegal-opcode detection.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal opcode parks the FSM in TRAP until reset).
module multicycle_control #(
  parameter int                  OPCODE_W = 8,
  parameter logic [OPCODE_W-1:0] OP_BASE  = 8'h29,
  parameter int                  TIMEOUT  = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  // Opcodes are contiguous from OP_BASE and wrap within the opcode width.
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = OP_BASE;
  localparam logic [OPCODE_W-1:0] OP_LW     = OP_BASE + OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW     = OP_BASE + OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ    = OP_BASE + OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BNE    = OP_BASE + OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI   = OP_BASE + OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_J      = OP_BASE + OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JALFOR = OP_BASE + OPCODE_W'(7);

  localparam int                CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  localparam logic [3:0] S_IDLE   = 4'h0;
  localparam logic [3:0] S_FETCH  = 4'h1;
  localparam logic [3:0] S_DECODE = 4'h2;
  localparam logic [3:0] S_MEMADR = 4'h3;
  localparam logic [3:0] S_MEMRD  = 4'h4;
  localparam logic [3:0] S_MEMWB  = 4'h5;
  localparam logic [3:0] S_MEMWR  = 4'h6;
  localparam logic [3:0] S_EXEC   = 4'h7;
  localparam logic [3:0] S_ALUWB  = 4'h8;
  localparam logic [3:0] S_BRANCH = 4'h9;
  localparam logic [3:0] S_ADDIEX = 4'hA;
  localparam logic [3:0] S_ADDIWB = 4'hB;
  localparam logic [3:0] S_JUMP   = 4'hC;
  localparam logic [3:0] S_JALFOR = 4'hD;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP   = 4'hF;
`endif

  logic [3:0]          state_q;
  logic [3:0]          state_d;
  logic [3:0]          dec_target;
  logic                dec_legal;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                fault_q;
  logic                waiting;
  logic                timeout;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = waiting && !bus.mem_ready && (wait_cnt == TIMEOUT_CNT);

  // The live opcode is decoded in DECODE; op_q only becomes valid one edge later.
  always_comb begin
    dec_target = S_FETCH;
    dec_legal  = 1'b1;
    case (bus.opcode)
      OP_RTYPE:      dec_target = S_EXEC;
      OP_LW, OP_SW:  dec_target = S_MEMADR;
      OP_BEQ, OP_BNE: dec_target = S_BRANCH;
      OP_ADDI:       dec_target = S_ADDIEX;
      OP_J:          dec_target = S_JUMP;
      OP_JALFOR:     dec_target = S_JALFOR;
      default: begin
        dec_legal = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        dec_target = S_TRAP;
`else
        dec_target = S_FETCH;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_target;
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_FETCH;
      end
      S_MEMWR:  if (bus.mem_ready || timeout) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JALFOR:
                state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // wait_cnt only survives a cycle that stays in a memory wait without completing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (waiting && !bus.mem_ready && !timeout) wait_cnt <= wait_cnt + CNT_ONE;
      else                                      wait_cnt <= '0;
      if (timeout) fault_q <= 1'b1;
    end
  end

  // Completion strobes in FETCH/MEMWR are qualified by mem_ready so a stall never double-commits.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_src        = 2'b00;
    bus.ir_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.wb_sel        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.retire        = 1'b0;
    bus.illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.illegal   = !dec_legal;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = 2'b01;
        bus.retire    = 1'b1;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        bus.retire    = bus.mem_ready;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
        bus.retire    = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        bus.branch_ne     = (op_q == OP_BNE);
        bus.retire        = 1'b1;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        bus.retire   = 1'b1;
      end
      S_JALFOR: begin
        bus.pc_write  = 1'b1;
        bus.pc_src    = 2'b10;
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b10;
        bus.wb_sel    = 2'b10;
        bus.retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fault = fault_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; honours CTRL_ILLEGAL_TRAP_EN when defined.
module tb_multicycle_control;

  // Packed control vector layout (bit 20 down to 0) used by every expected value below.
  localparam logic [20:0] C_PCW        = 21'h100000;
  localparam logic [20:0] C_PWC        = 21'h080000;
  localparam logic [20:0] C_BNE        = 21'h040000;
  localparam logic [20:0] C_SRC_ALUOUT = 21'h010000;
  localparam logic [20:0] C_SRC_JMP    = 21'h020000;
  localparam logic [20:0] C_IRW        = 21'h008000;
  localparam logic [20:0] C_IORD       = 21'h004000;
  localparam logic [20:0] C_MRD        = 21'h002000;
  localparam logic [20:0] C_MWR        = 21'h001000;
  localparam logic [20:0] C_DST_LINK   = 21'h000800;
  localparam logic [20:0] C_DST_RD     = 21'h000400;
  localparam logic [20:0] C_WB_PC      = 21'h000200;
  localparam logic [20:0] C_WB_MDR     = 21'h000100;
  localparam logic [20:0] C_RW         = 21'h000080;
  localparam logic [20:0] C_SRCA       = 21'h000040;
  localparam logic [20:0] C_B_OFF      = 21'h000030;
  localparam logic [20:0] C_B_IMM      = 21'h000020;
  localparam logic [20:0] C_B_INC      = 21'h000010;
  localparam logic [20:0] C_OP_FN      = 21'h000008;
  localparam logic [20:0] C_OP_SUB     = 21'h000004;
  localparam logic [20:0] C_RET        = 21'h000002;
  localparam logic [20:0] C_ILL        = 21'h000001;

  localparam logic [20:0] F_RDY  = C_PCW | C_IRW | C_MRD | C_B_INC;
  localparam logic [20:0] F_WAIT = C_MRD | C_B_INC;
  localparam logic [20:0] BR     = C_SRCA | C_OP_SUB | C_PWC | C_SRC_ALUOUT | C_RET;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [20:0] ctl;
  logic [25:0] obs;
  logic [25:0] expv;

  multicycle_control_if #(.OPCODE_W(8)) bus ();

  multicycle_control #(
    .OPCODE_W(8),
    .OP_BASE (8'h29),
    .TIMEOUT (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign ctl = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_src, bus.ir_write,
                bus.iord, bus.mem_read, bus.mem_write, bus.reg_dst, bus.wb_sel,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.retire,
                bus.illegal};
  assign obs = {bus.state, bus.fault, ctl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 8'h29;
    tick();
    tick();
    vectors++;
    if (obs !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: state/fault/ctl got %h expected %h", obs, 26'h0);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (obs !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, 26'h0);
    end
    tick();
    expv = {4'h1, 1'b0, F_RDY};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL reset_first_fetch: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  es [6] = '{4'h0, 4'h1, 4'h2, 4'h7, 4'h8, 4'h1};
    logic [20:0] ec [6] = '{21'h0, F_RDY, C_B_OFF, C_SRCA | C_OP_FN,
                            C_RW | C_DST_RD | C_RET, F_RDY};
    do_reset();
    bus.opcode    = 8'h29;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      expv = {es[i], 1'b0, ec[i]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL rtype step %0d: got %h expected %h", i, obs, expv);
      end
      tick();
    end
  endtask

  task automatic test_lw_stall();
    logic        rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  es  [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4, 4'h5, 4'h1};
    logic [20:0] ec  [10] = '{21'h0, F_RDY, C_B_OFF, C_SRCA | C_B_IMM,
                              C_IORD | C_MRD, C_IORD | C_MRD, C_IORD | C_MRD, C_IORD | C_MRD,
                              C_RW | C_WB_MDR | C_RET, F_RDY};
    do_reset();
    bus.opcode = 8'h2A;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      expv = {es[i], 1'b0, ec[i]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL lw_stall step %0d: got %h expected %h", i, obs, expv);
      end
      tick();
    end
  endtask

  // The live opcode is swapped while in BRANCH so branch_ne must come from the latched opcode.
  task automatic test_branch();
    logic [7:0]  op [8] = '{8'h2D, 8'h2D, 8'h2D, 8'h2C, 8'h2C, 8'h2C, 8'h2D, 8'h2D};
    logic [3:0]  es [8] = '{4'h0, 4'h1, 4'h2, 4'h9, 4'h1, 4'h2, 4'h9, 4'h1};
    logic [20:0] ec [8] = '{21'h0, F_RDY, C_B_OFF, BR | C_BNE, F_RDY, C_B_OFF, BR, F_RDY};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.opcode = op[i];
      #1;
      expv = {es[i], 1'b0, ec[i]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL branch step %0d: got %h expected %h", i, obs, expv);
      end
      tick();
    end
  endtask

  task automatic test_jumps_addi();
    logic [7:0]  op [12] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h2E, 8'h2E, 8'h2E, 8'h2E,
                             8'h2F, 8'h2F, 8'h2F, 8'h2F};
    logic [3:0]  es [12] = '{4'h0, 4'h1, 4'h2, 4'hD, 4'h1, 4'h2, 4'hA, 4'hB,
                             4'h1, 4'h2, 4'hC, 4'h1};
    logic [20:0] ec [12] = '{21'h0, F_RDY, C_B_OFF,
                             C_PCW | C_SRC_JMP | C_RW | C_DST_LINK | C_WB_PC | C_RET,
                             F_RDY, C_B_OFF, C_SRCA | C_B_IMM, C_RW | C_RET,
                             F_RDY, C_B_OFF, C_PCW | C_SRC_JMP | C_RET, F_RDY};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.opcode = op[i];
      #1;
      expv = {es[i], 1'b0, ec[i]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL jumps_addi step %0d: got %h expected %h", i, obs, expv);
      end
      tick();
    end
  endtask

  // A clean sw, then a second sw whose MEMWR never sees mem_ready: 16 wait cycles, then abort.
  task automatic test_timeout();
    logic        rdy [27];
    logic [3:0]  es  [27];
    logic        ef  [27];
    logic [20:0] ec  [27];
    rdy[0] = 1'b1; es[0] = 4'h0; ec[0] = 21'h0;
    rdy[1] = 1'b1; es[1] = 4'h1; ec[1] = F_RDY;
    rdy[2] = 1'b1; es[2] = 4'h2; ec[2] = C_B_OFF;
    rdy[3] = 1'b1; es[3] = 4'h3; ec[3] = C_SRCA | C_B_IMM;
    rdy[4] = 1'b1; es[4] = 4'h6; ec[4] = C_IORD | C_MWR | C_RET;
    rdy[5] = 1'b1; es[5] = 4'h1; ec[5] = F_RDY;
    rdy[6] = 1'b1; es[6] = 4'h2; ec[6] = C_B_OFF;
    rdy[7] = 1'b1; es[7] = 4'h3; ec[7] = C_SRCA | C_B_IMM;
    for (int i = 0; i < 27; i++) ef[i] = (i >= 24);
    for (int i = 8; i < 24; i++) begin
      rdy[i] = 1'b0;
      es[i]  = 4'h6;
      ec[i]  = C_IORD | C_MWR;
    end
    rdy[24] = 1'b0; es[24] = 4'h1; ec[24] = F_WAIT;
    rdy[25] = 1'b1; es[25] = 4'h1; ec[25] = F_RDY;
    rdy[26] = 1'b1; es[26] = 4'h2; ec[26] = C_B_OFF;
    do_reset();
    bus.opcode = 8'h2B;
    for (int i = 0; i < 27; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      expv = {es[i], ef[i], ec[i]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL timeout step %0d: got %h expected %h", i, obs, expv);
      end
      tick();
    end
    do_reset();
    #1;
    vectors++;
    if (obs !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL fault_cleared_by_reset: got %h expected %h", obs, 26'h0);
    end
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    bus.opcode    = 8'h2A;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    #1;
    expv = {4'h4, 1'b0, C_IORD | C_MRD};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL memrd_before_reset: got %h expected %h", obs, expv);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_immediate: got %h expected %h", obs, 26'h0);
    end
    tick();
    vectors++;
    if (obs !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_held_idle: got %h expected %h", obs, 26'h0);
    end
    reset = 1'b0;
    tick();
    expv = {4'h1, 1'b0, F_WAIT};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL fetch_after_reset: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic [7:0]  op [8] = '{8'h00, 8'h00, 8'h00, 8'h29, 8'h29, 8'h29, 8'h29, 8'h29};
    logic [3:0]  es [8] = '{4'h0, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [20:0] ec [8] = '{21'h0, F_RDY, C_B_OFF | C_ILL, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};
`else
    logic [7:0]  op [8] = '{8'h00, 8'h00, 8'h00, 8'h31, 8'h31, 8'h31, 8'h28, 8'h28};
    logic [3:0]  es [8] = '{4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
    logic [20:0] ec [8] = '{21'h0, F_RDY, C_B_OFF | C_ILL, F_RDY, C_B_OFF | C_ILL,
                            F_RDY, C_B_OFF | C_ILL, F_RDY};
`endif
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.opcode = op[i];
      #1;
      expv = {es[i], 1'b0, ec[i]};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL illegal step %0d: got %h expected %h", i, obs, expv);
      end
      tick();
    end
    do_reset();
    #1;
    vectors++;
    if (obs !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL illegal_reset_idle: got %h expected %h", obs, 26'h0);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.opcode    = 8'h00;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_jumps_addi();
    test_timeout();
    test_reset_mid_memrd();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
